// File: rtl/bp_mem_port_arbiter.sv
// Shares one memory command/response port between num_cce_p CCEs, one transaction
// at a time, round-robin across CCEs with writes ahead of reads inside a CCE.
module bp_mem_port_arbiter #(
  parameter int num_cce_p         = 2,
  parameter int cmd_width_p       = 64,
  parameter int data_cmd_width_p  = 576,
  parameter int resp_width_p      = 64,
  parameter int data_resp_width_p = 576,
  parameter int timeout_p         = 1024,
  localparam int lg_num_cce_lp    = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic [num_cce_p*cmd_width_p-1:0]       cce_cmd_i,
  input  logic [num_cce_p-1:0]                   cce_cmd_v_i,
  output logic [num_cce_p-1:0]                   cce_cmd_yumi_o,
  input  logic [num_cce_p*data_cmd_width_p-1:0]  cce_data_cmd_i,
  input  logic [num_cce_p-1:0]                   cce_data_cmd_v_i,
  output logic [num_cce_p-1:0]                   cce_data_cmd_yumi_o,

  output logic [resp_width_p-1:0]                cce_resp_o,
  output logic [num_cce_p-1:0]                   cce_resp_v_o,
  input  logic [num_cce_p-1:0]                   cce_resp_ready_i,
  output logic [data_resp_width_p-1:0]           cce_data_resp_o,
  output logic [num_cce_p-1:0]                   cce_data_resp_v_o,
  input  logic [num_cce_p-1:0]                   cce_data_resp_ready_i,

  output logic [cmd_width_p-1:0]                 mem_cmd_o,
  output logic                                   mem_cmd_v_o,
  input  logic                                   mem_cmd_yumi_i,
  output logic [data_cmd_width_p-1:0]            mem_data_cmd_o,
  output logic                                   mem_data_cmd_v_o,
  input  logic                                   mem_data_cmd_yumi_i,

  input  logic [resp_width_p-1:0]                mem_resp_i,
  input  logic                                   mem_resp_v_i,
  output logic                                   mem_resp_ready_o,
  input  logic [data_resp_width_p-1:0]           mem_data_resp_i,
  input  logic                                   mem_data_resp_v_i,
  output logic                                   mem_data_resp_ready_o,

  output logic [lg_num_cce_lp-1:0]               owner_o,
  output logic                                   busy_o,
  output logic                                   timeout_o
);

  localparam int cnt_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [cnt_width_lp-1:0] timeout_cnt_lp = cnt_width_lp'(timeout_p);
  localparam logic [lg_num_cce_lp-1:0] last_cce_lp   = lg_num_cce_lp'(num_cce_p - 1);

  localparam logic [1:0] idle_s  = 2'd0;
  localparam logic [1:0] issue_s = 2'd1;
  localparam logic [1:0] wait_s  = 2'd2;

  logic [1:0]               state_r;
  logic [lg_num_cce_lp-1:0] rr_ptr_r, owner_r, grant_idx, next_ptr;
  logic                     is_wr_r, timeout_r, grant_found;
  logic [cnt_width_lp-1:0]  wait_cnt_r, wait_cnt_inc;
  logic [num_cce_p-1:0]     req;
  logic                     in_issue, in_wait, cmd_fire, resp_fire;
  int                       owner_idx, scan_idx;

  assign req          = cce_data_cmd_v_i | cce_cmd_v_i;
  assign owner_idx    = int'(owner_r);
  assign next_ptr     = (owner_r == last_cce_lp) ? '0 : owner_r + 1'b1;
  assign wait_cnt_inc = wait_cnt_r + 1'b1;

  // Handshakes are gated by reset so a transaction in flight is refused immediately.
  assign in_issue = reset_n_i && (state_r == issue_s);
  assign in_wait  = reset_n_i && (state_r == wait_s);

  // Scan downward so the candidate closest to rr_ptr_r is the last one written.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int i = num_cce_p - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr_r) + i;
      if (scan_idx >= num_cce_p) scan_idx = scan_idx - num_cce_p;
      if (req[scan_idx]) begin
        grant_idx   = scan_idx[lg_num_cce_lp-1:0];
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the branches infers a latch.
    mem_cmd_o             = '0;
    mem_cmd_v_o           = 1'b0;
    mem_data_cmd_o        = '0;
    mem_data_cmd_v_o      = 1'b0;
    cce_cmd_yumi_o        = '0;
    cce_data_cmd_yumi_o   = '0;
    cce_resp_o            = '0;
    cce_resp_v_o          = '0;
    mem_resp_ready_o      = 1'b0;
    cce_data_resp_o       = '0;
    cce_data_resp_v_o     = '0;
    mem_data_resp_ready_o = 1'b0;
    if (in_issue) begin
      if (is_wr_r) begin
        mem_data_cmd_o                = cce_data_cmd_i[owner_idx*data_cmd_width_p +: data_cmd_width_p];
        mem_data_cmd_v_o              = cce_data_cmd_v_i[owner_r];
        cce_data_cmd_yumi_o[owner_r]  = mem_data_cmd_v_o & mem_data_cmd_yumi_i;
      end else begin
        mem_cmd_o                     = cce_cmd_i[owner_idx*cmd_width_p +: cmd_width_p];
        mem_cmd_v_o                   = cce_cmd_v_i[owner_r];
        cce_cmd_yumi_o[owner_r]       = mem_cmd_v_o & mem_cmd_yumi_i;
      end
    end
    if (in_wait) begin
      if (is_wr_r) begin
        cce_resp_o                    = mem_resp_i;
        cce_resp_v_o[owner_r]         = mem_resp_v_i;
        mem_resp_ready_o              = mem_resp_v_i & cce_resp_ready_i[owner_r];
      end else begin
        cce_data_resp_o               = mem_data_resp_i;
        cce_data_resp_v_o[owner_r]    = mem_data_resp_v_i;
        mem_data_resp_ready_o         = mem_data_resp_v_i & cce_data_resp_ready_i[owner_r];
      end
    end
  end

  assign cmd_fire  = (mem_cmd_v_o & mem_cmd_yumi_i) | (mem_data_cmd_v_o & mem_data_cmd_yumi_i);
  assign resp_fire = (mem_resp_v_i & mem_resp_ready_o) | (mem_data_resp_v_i & mem_data_resp_ready_o);

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
    if (!reset_n_i) begin
      state_r    <= idle_s;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      is_wr_r    <= 1'b0;
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        idle_s: if (grant_found) begin
          owner_r <= grant_idx;
          is_wr_r <= cce_data_cmd_v_i[grant_idx];
          state_r <= issue_s;
        end
        issue_s: if (cmd_fire) begin
          wait_cnt_r <= '0;
          state_r    <= wait_s;
        end
        wait_s: if (resp_fire) begin
          rr_ptr_r <= next_ptr;
          state_r  <= idle_s;
        end else if (wait_cnt_r != timeout_cnt_lp) begin
          wait_cnt_r <= wait_cnt_inc;
          if (wait_cnt_inc == timeout_cnt_lp) timeout_r <= 1'b1;
        end
        default: state_r <= idle_s;
      endcase
    end
  end

  assign owner_o   = owner_r;
  assign busy_o    = (state_r != idle_s);
  assign timeout_o = timeout_r;

endmodule
